// File: rtl/ram512_arbiter_pkg.sv
// Shared constants and state encoding for the two-port RAM arbiter.
package ram512_arbiter_pkg;

    localparam int RAM_AW = 9;
    localparam int RAM_DW = 16;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    // Lock state owned by the given port.
    function automatic arb_state_e lock_state(input logic port);
        return port ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/ram512_arbiter_rr_arb2.sv
// Two-input grant logic: round-robin or fixed priority while arbitrating,
// owner-only while a lock is held. Grants only ever go to valid ports.
module ram512_arbiter_rr_arb2
    import ram512_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       mode,
    input  arb_state_e state,
    output logic [1:0] grant
);

    // Pick at most one valid port according to the current ownership state.
    always_comb begin
        grant = 2'b00;
        case (state)
            ST_ARB: begin
                if (valid == 2'b11) begin
                    // Contention: fixed mode favours port 0, round-robin
                    // favours the port that did not win last.
                    grant = (mode || last_grant) ? 2'b01 : 2'b10;
                end else begin
                    grant = valid;
                end
            end
            ST_LOCK0: grant = {1'b0, valid[0]};
            ST_LOCK1: grant = {valid[1], 1'b0};
            default:  grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram512_arbiter.sv
// Shares one 512x16 RAM (sync write, combinational read) between two
// requesters with per-cycle arbitration, bounded lock and registered reads.
//
// Handshake: a transfer on port k happens at a rising edge where
// reqk_valid && reqk_ready. Ready is combinational from valid, the lock
// state and last_grant; it never asserts without valid and at most one
// port is ready per cycle. A read answers with respk_valid high for one
// cycle after the transfer edge; writes produce no response.
module ram512_arbiter
    import ram512_arbiter_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int LOCK_MAX      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [RAM_AW-1:0] req0_addr,
    input  logic [RAM_DW-1:0] req0_wdata,
    output logic              resp0_valid,
    output logic [RAM_DW-1:0] resp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [RAM_AW-1:0] req1_addr,
    input  logic [RAM_DW-1:0] req1_wdata,
    output logic              resp1_valid,
    output logic [RAM_DW-1:0] resp1_rdata,
    output logic [RAM_DW-1:0] mem_in,
    output logic              mem_load,
    output logic [RAM_AW-1:0] mem_address,
    input  logic [RAM_DW-1:0] mem_out
);

    localparam logic       MODE_FIXED = (PRIORITY_MODE != 0);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [RAM_DW-1:0] resp0_rdata_q, resp0_rdata_d;
    logic [RAM_DW-1:0] resp1_rdata_q, resp1_rdata_d;

    logic [1:0] grant_raw;
    logic [1:0] grant;
    logic       lock_owner;
    logic       owner_lock;
    logic       owner_xfer;

    ram512_arbiter_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .mode       (MODE_FIXED),
        .state      (state_q),
        .grant      (grant_raw)
    );

    // Nothing is granted while reset is asserted.
    always_comb begin
        grant = reset ? 2'b00 : grant_raw;
    end

    assign lock_owner = (state_q == ST_LOCK1);
    assign owner_lock = lock_owner ? req1_lock : req0_lock;
    assign owner_xfer = lock_owner ? grant[1] : grant[0];

    // State register plus registered read responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ARB;
            last_grant_q  <= 1'b1;
            lock_cnt_q    <= 8'd0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp1_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            lock_cnt_q    <= lock_cnt_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp1_rdata_q <= resp1_rdata_d;
        end
    end

    // Next state: enter a lock on a locking transfer, leave on an unlocking
    // owner transfer or when the lock has been held LOCK_MAX cycles.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        if (grant[0]) last_grant_d = 1'b0;
        if (grant[1]) last_grant_d = 1'b1;
        case (state_q)
            ST_ARB: begin
                lock_cnt_d = 8'd0;
                if (grant[0] && req0_lock) begin
                    state_d = lock_state(1'b0);
                end else if (grant[1] && req1_lock) begin
                    state_d = lock_state(1'b1);
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d      = ST_ARB;
                    lock_cnt_d   = 8'd0;
                    last_grant_d = lock_owner;
                end else if (owner_xfer && !owner_lock) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = 8'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_ARB;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    // Read responses: capture RAM data on a read transfer, hold otherwise.
    always_comb begin
        resp0_valid_d = grant[0] && !req0_we;
        resp1_valid_d = grant[1] && !req1_we;
        resp0_rdata_d = resp0_valid_d ? mem_out : resp0_rdata_q;
        resp1_rdata_d = resp1_valid_d ? mem_out : resp1_rdata_q;
    end

    // Outputs: ready flags and RAM drive from the granted port, zero if idle.
    always_comb begin
        req0_ready  = grant[0];
        req1_ready  = grant[1];
        mem_address = '0;
        mem_in      = '0;
        mem_load    = 1'b0;
        if (grant[0]) begin
            mem_address = req0_addr;
            mem_in      = req0_wdata;
            mem_load    = req0_we;
        end else if (grant[1]) begin
            mem_address = req1_addr;
            mem_in      = req1_wdata;
            mem_load    = req1_we;
        end
    end

    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_rdata = resp0_rdata_q;
    assign resp1_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Bench for ram512_arbiter: two instances (round-robin with LOCK_MAX=4 and
// fixed priority with LOCK_MAX=16) share one stimulus stream. A behavioural
// model tracks ownership, last winner and an expected memory image.
module tb_ram512_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [1:0]            v, we, lk;
    logic [1:0][8:0]       a;
    logic [1:0][15:0]      d;

    logic [1:0]            rdy0, rdy1, rv0, rv1, ld;
    logic [1:0][15:0]      rd0, rd1, min, mout;
    logic [1:0][8:0]       madr;

    int n_vec = 0;
    int n_err = 0;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        logic [15:0] ram [512];
        initial for (int i = 0; i < 512; i++) ram[i] <= 16'h0;
        always @(posedge clk) if (ld[g]) ram[madr[g]] <= min[g];
        assign mout[g] = ram[madr[g]];

        ram512_arbiter #(.PRIORITY_MODE(g), .LOCK_MAX(g == 0 ? 4 : 16)) u_dut (
            .clk         (clk),
            .reset       (rst),
            .req0_valid  (v[0]),
            .req0_ready  (rdy0[g]),
            .req0_we     (we[0]),
            .req0_lock   (lk[0]),
            .req0_addr   (a[0]),
            .req0_wdata  (d[0]),
            .resp0_valid (rv0[g]),
            .resp0_rdata (rd0[g]),
            .req1_valid  (v[1]),
            .req1_ready  (rdy1[g]),
            .req1_we     (we[1]),
            .req1_lock   (lk[1]),
            .req1_addr   (a[1]),
            .req1_wdata  (d[1]),
            .resp1_valid (rv1[g]),
            .resp1_rdata (rd1[g]),
            .mem_in      (min[g]),
            .mem_load    (ld[g]),
            .mem_address (madr[g]),
            .mem_out     (mout[g])
        );
    end

    // ---------------- behavioural model ----------------
    int          m_owner  [2];   // -1: nobody owns the RAM
    int          m_locked [2];   // cycles spent under the current lock
    int          m_last   [2];
    logic [15:0] m_mem    [2][512];
    logic [1:0]  m_rv     [2];
    logic [15:0] m_rd     [2][2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 512; j++) m_mem[i][j] = 16'h0;
            m_owner[i] = -1; m_locked[i] = 0; m_last[i] = 1;
            m_rv[i] = 2'b00; m_rd[i][0] = 16'h0; m_rd[i][1] = 16'h0;
        end
    end

    function automatic int lmax(input int i);
        return (i == 0) ? 4 : 16;
    endfunction

    // Which port (or -1) the instance must grant this cycle.
    function automatic int exp_grant(input int i);
        if (rst) return -1;
        if (m_owner[i] >= 0) return v[m_owner[i]] ? m_owner[i] : -1;
        if (v[0] && v[1]) return (i == 1) ? 0 : 1 - m_last[i];
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int gi;
            gi = exp_grant(i);
            if (rst) begin
                m_owner[i] = -1; m_locked[i] = 0; m_last[i] = 1;
                m_rv[i] = 2'b00; m_rd[i][0] = 16'h0; m_rd[i][1] = 16'h0;
            end else begin
                m_rv[i] = 2'b00;
                if (gi >= 0) begin
                    if (we[gi]) m_mem[i][a[gi]] = d[gi];
                    else begin
                        m_rv[i][gi] = 1'b1;
                        m_rd[i][gi] = m_mem[i][a[gi]];
                    end
                    m_last[i] = gi;
                end
                if (m_owner[i] >= 0) begin
                    m_locked[i] = m_locked[i] + 1;
                    if (m_locked[i] == lmax(i) || (gi == m_owner[i] && !lk[gi])) begin
                        m_last[i]   = m_owner[i];
                        m_owner[i]  = -1;
                        m_locked[i] = 0;
                    end
                end else if (gi >= 0 && lk[gi]) begin
                    m_owner[i]  = gi;
                    m_locked[i] = 0;
                end
            end
        end
    end

    task automatic chk(input int i, input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s t=%0t got=%h exp=%h", i, nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int gi;
            gi = exp_grant(i);
            chk(i, "req0_ready",  16'(rdy0[i]), 16'(gi == 0));
            chk(i, "req1_ready",  16'(rdy1[i]), 16'(gi == 1));
            chk(i, "mem_address", 16'(madr[i]), (gi >= 0) ? 16'(a[gi]) : 16'h0);
            chk(i, "mem_in",      min[i],       (gi >= 0) ? d[gi] : 16'h0);
            chk(i, "mem_load",    16'(ld[i]),   (gi >= 0) ? 16'(we[gi]) : 16'h0);
            chk(i, "resp0_valid", 16'(rv0[i]),  16'(m_rv[i][0]));
            chk(i, "resp1_valid", 16'(rv1[i]),  16'(m_rv[i][1]));
            chk(i, "resp0_rdata", rd0[i],       m_rd[i][0]);
            chk(i, "resp1_rdata", rd1[i],       m_rd[i][1]);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v = 2'b00; we = 2'b00; lk = 2'b00;
    endtask

    task automatic set_req(input int p, input logic we_i, input logic lk_i,
                           input logic [8:0] ad, input logic [15:0] dt);
        v[p] = 1'b1; we[p] = we_i; lk[p] = lk_i; a[p] = ad; d[p] = dt;
    endtask

    initial begin
        rst = 1'b1; idle(); a = '0; d = '0;
        tick(); tick();
        chk(0, "rst_resp0_valid", 16'(rv0[0]), 16'h0);
        chk(0, "rst_resp1_rdata", rd1[0], 16'h0);
        rst = 1'b0;

        // Write then read back on port 0.
        set_req(0, 1'b1, 1'b0, 9'h1A5, 16'hBEEF);
        tick();
        set_req(0, 1'b0, 1'b0, 9'h1A5, 16'h0000);
        #1 chk(0, "rd_ready0", 16'(rdy0[0]), 16'h1);
        tick(); idle();
        #1;
        chk(0, "beef_valid", 16'(rv0[0]), 16'h1);
        chk(0, "beef_data",  rd0[0], 16'hBEEF);
        chk(1, "beef_data",  rd0[1], 16'hBEEF);
        chk(0, "beef_resp1", 16'(rv1[0]), 16'h0);
        tick();
        #1;
        chk(0, "beef_pulse", 16'(rv0[0]), 16'h0);
        chk(0, "beef_hold",  rd0[0], 16'hBEEF);

        // Preload, then both ports read continuously.
        set_req(0, 1'b1, 1'b0, 9'h010, 16'h0010); tick(); idle();
        set_req(1, 1'b1, 1'b0, 9'h011, 16'h0011); tick(); idle();
        set_req(0, 1'b0, 1'b0, 9'h010, 16'h0000);
        set_req(1, 1'b0, 1'b0, 9'h011, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk(0, "rr_rdy0", 16'(rdy0[0]), 16'(k % 2 == 0));
            chk(0, "rr_rdy1", 16'(rdy1[0]), 16'(k % 2 == 1));
            chk(1, "fp_rdy0", 16'(rdy0[1]), 16'h1);
            chk(1, "fp_rdy1", 16'(rdy1[1]), 16'h0);
            tick();
        end
        #1;
        chk(0, "rr_resp1", rd1[0], 16'h0011);
        chk(1, "fp_resp0", rd0[1], 16'h0010);

        // Port 1 locked write burst while port 0 keeps requesting.
        idle();
        set_req(0, 1'b0, 1'b0, 9'h010, 16'h0000);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_req(1, 1'b1, (b < 3), 9'(256 + b), 16'(16'h0A00 + b));
            #1;
            chk(0, "lk1_rdy0", 16'(rdy0[0]), 16'h0);
            chk(0, "lk1_rdy1", 16'(rdy1[0]), 16'h1);
            tick();
        end
        v[1] = 1'b0;
        #1 chk(0, "lk1_release", 16'(rdy0[0]), 16'h1);
        tick(); idle();
        for (int b = 0; b < 3; b++) begin
            set_req(1, 1'b0, 1'b0, 9'(256 + b), 16'h0000);
            tick();
            #1 chk(0, "lk1_readback", rd1[0], 16'(16'h0A00 + b));
        end
        idle();

        // Port 0 holds lock; round-robin instance must force release.
        set_req(0, 1'b0, 1'b1, 9'h020, 16'h0000);
        set_req(1, 1'b0, 1'b0, 9'h021, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk(0, "lk0_rdy0", 16'(rdy0[0]), 16'h1);
            chk(0, "lk0_rdy1", 16'(rdy1[0]), 16'h0);
            tick();
        end
        #1 chk(0, "lk0_forced", 16'(rdy1[0]), 16'h1);
        lk[0] = 1'b0;
        tick(); idle();

        // Reset while port 1 is locked with a read response outstanding.
        set_req(1, 1'b0, 1'b1, 9'h011, 16'h0000);
        tick();
        rst = 1'b1;
        #1;
        chk(0, "rst_ready1", 16'(rdy1[0]), 16'h0);
        chk(0, "rst_load",   16'(ld[0]), 16'h0);
        tick();
        rst = 1'b0; idle();
        set_req(0, 1'b0, 1'b0, 9'h010, 16'h0000);
        set_req(1, 1'b0, 1'b0, 9'h011, 16'h0000);
        #1;
        chk(0, "post_rst_rv1", 16'(rv1[0]), 16'h0);
        chk(0, "post_rst_rd1", rd1[0], 16'h0);
        chk(0, "post_rst_rdy0", 16'(rdy0[0]), 16'h1);
        chk(1, "post_rst_rdy0", 16'(rdy0[1]), 16'h1);
        tick(); idle();

        // Randomized traffic with alternating low/high lock pressure.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < 2; p++) begin
                v[p]  = ($urandom_range(0, 3) != 0);
                we[p] = ($urandom_range(0, 2) == 0);
                lk[p] = ($urandom_range(0, 7) < (((n / 128) % 2 == 1) ? 7 : 2));
                a[p]  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
                d[p]  = 16'($urandom);
            end
            tick();
        end
        rst = 1'b0; idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram512_arbiter.md
Name: ram512_arbiter

Overview:
- Two-requester arbiter that shares one 512x16 RAM (9-bit address, 16-bit data, synchronous write on clk, combinational read) between two masters, e.g. CPU data port and a loader/debug port.
- Per-cycle round-robin or fixed-priority grant, optional bounded burst lock, registered read responses.
- Sits between the requesters and the RAM's in/load/address/out pins.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority, port 0 always wins.
- LOCK_MAX, 16, maximum consecutive cycles one port may hold a lock (range 1..255).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 transaction request
- req0_ready  output  1  port 0 granted this cycle (combinational)
- req0_we  input  1  1 = write, 0 = read
- req0_lock  input  1  keep ownership after this transaction
- req0_addr  input  9  word address
- req0_wdata  input  16  write data
- resp0_valid  output  1  read data valid, one-cycle pulse
- resp0_rdata  output  16  read data
- req1_*, resp1_*: same as port 0, for port 1
- mem_in  output  16  to RAM in
- mem_load  output  1  to RAM load
- mem_address  output  9  to RAM address
- mem_out  input  16  from RAM out

Behaviour:
- Transfer on port k: reqk_valid && reqk_ready at a rising edge. At most one grant per cycle. Ready is combinational from valid, state and last_grant.
- FSM states:
  - ARB: grant among valid ports.
    - Round-robin: if both valid, grant the port other than last_grant.
    - PRIORITY_MODE=1: port 0 wins.
  - LOCK0 / LOCK1: only the owning port can be granted. The other port's ready is 0.
- Transitions:
  - ARB -> LOCKk when port k transfers with reqk_lock=1.
  - LOCKk -> ARB when port k transfers with reqk_lock=0; that transfer completes.
  - LOCKk -> ARB when lock_cnt reaches LOCK_MAX-1 on any cycle, transfer or not. That cycle's transfer still completes. last_grant=k.
  - In LOCKk with reqk_valid=0: stay locked; lock_cnt keeps counting.
- lock_cnt (8 bit):
  - Cleared on entering LOCKk.
  - +1 every cycle in LOCKk.
  - Held at 0 in ARB.
- last_grant updates to k on every transfer by port k. Reset value is 1, so port 0 wins the first contention.
- Memory drive:
  - Granted port: mem_address=reqk_addr, mem_in=reqk_wdata, mem_load=reqk_we.
  - No grant: mem_address=0, mem_in=0, mem_load=0.
- Write: takes effect at the transfer edge. No response is produced.
- Read: at the transfer edge, respk_rdata <= mem_out and respk_valid <= 1 for exactly one cycle. Latency is 1 cycle.
  - respk_rdata holds its value until the next read on that port.
  - A read issued the cycle after a write to the same address returns the new data.
- Back-to-back reads on the same port give a continuous resp_valid with new data each cycle.
- reset (synchronous, overrides everything):
  - state=ARB, last_grant=1, lock_cnt=0.
  - resp0/1_valid=0, resp0/1_rdata=0.
  - Ready outputs and mem_load are 0 during the reset cycle.
  - Reset mid-lock drops ownership. A read pending response is discarded.
- Address and data are passed unmodified; there is no range checking.

Decomposition:
- Shared package constants:
  - RAM_AW=9, RAM_DW=16.
  - State encoding: ST_ARB=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2.
- Sub-module rr_arb2: 2-input grant logic taking valid[1:0], last_grant, mode and state, returning grant[1:0]. Everything else stays in the top level.

Test Plan:
- Reset, then port 0 writes 16'hBEEF @9'h1A5; next cycle port 0 reads 9'h1A5 -> resp0_valid pulses 1 cycle after the read, resp0_rdata=16'hBEEF; resp1_valid stays 0.
- Both ports continuously read (port 0 @9'h010, port 1 @9'h011, preloaded 16'h0010/16'h0011), round-robin -> grants alternate 0,1,0,1 starting with port 0; each resp valid every other cycle with correct data.
- PRIORITY_MODE=1, both valid for 4 cycles -> req1_ready=0 throughout; port 0 completes 4 transfers.
- Port 1 writes with lock=1 for 3 beats (9'h100..9'h102 <= 16'h0A00..16'h0A02) then lock=0, while port 0 is valid -> port 0 starved exactly 4 cycles, granted on cycle 5; readback returns 16'h0A00..16'h0A02.
- LOCK_MAX=4, port 0 holds lock=1 continuously, port 1 valid -> forced release after 4 locked cycles; port 1 granted next cycle.
- Assert reset during LOCK1 with a read in flight -> next cycle state ARB, resp1_valid=0, resp1_rdata=0; with both valid after reset, port 0 granted first.
